// File: rtl/axi_interconnect_crossbar_rsp_route_pkg.sv
// Shared crossbar definitions: AXI response codes, default sizes and the
// index/pointer width helpers used by the return-path blocks.
package axi_interconnect_crossbar_rsp_route_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int unsigned DEF_NUM    = 8;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_DATA_W = 64;

  // A slave that keeps rvalid up this long with nothing outstanding is flagged.
  localparam int unsigned EMPTY_RVALID_LIMIT = 16;

  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned ptrWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_rsp_route_idx_fifo.sv
// In-order FIFO of master indices with wrap-flag pointers; shared by the
// R and B return paths of the crossbar.
module axi_interconnect_crossbar_idx_fifo
  import axi_interconnect_crossbar_rsp_route_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned WIDTH = 3,
  localparam int unsigned PTR_W = ptrWidth(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] count_o
);

  localparam int unsigned AW = PTR_W - 1;

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pushEn, popEn;

  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign pushEn = push_i && !full_o;
  assign popEn  = pop_i && !empty_o;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (pushEn) wptr_q <= wptr_q + PTR_W'(1);
      if (popEn)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: an entry is only read once the pointers cover it.
  always_ff @(posedge clk_sys) begin
    if (pushEn) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/axi_interconnect_crossbar_rsp_route.sv
// Read-response return path: routes slave R beats to the master recorded at
// AR time, in order, through a one-deep registered output stage.
module axi_interconnect_crossbar_rsp_route
  import axi_interconnect_crossbar_rsp_route_pkg::*;
#(
  parameter  int unsigned NUM    = DEF_NUM,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned WIDTH  = idxWidth(NUM),
  localparam int unsigned PTR_W  = ptrWidth(DEPTH)
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              ar_push,
  input  logic [WIDTH-1:0]  ar_user,
  output logic              ar_full,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  output logic [NUM-1:0]    m_rvalid,
  input  logic [NUM-1:0]    m_rready,
  output logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        m_rresp,
  output logic              m_rlast,
  output logic [PTR_W-1:0]  outstanding,
  output logic              err_unexp
);

  localparam int unsigned CNT_W = $clog2(EMPTY_RVALID_LIMIT) + 1;

  logic [WIDTH-1:0]  headUser;
  logic              fifoEmpty, headValid;
  logic              outVld_q, outVld_d;
  logic [WIDTH-1:0]  outUser_q, outUser_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [1:0]        outResp_q, outResp_d;
  logic              outLast_q, outLast_d;
  logic              outAccept, beatTaken, popBeat, emptyRvalid;
  logic [CNT_W-1:0]  emptyCnt_q, emptyCnt_d;
  logic              err_q, err_d;

  axi_interconnect_crossbar_idx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_idx_fifo (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .push_i      (ar_push),
    .push_data_i (ar_user),
    .pop_i       (popBeat),
    .head_o      (headUser),
    .full_o      (ar_full),
    .empty_o     (fifoEmpty),
    .count_o     (outstanding)
  );

  assign headValid   = !fifoEmpty;
  assign outAccept   = outVld_q && m_rready[outUser_q];
  assign s_rready    = headValid && (!outVld_q || outAccept);
  assign beatTaken   = s_rvalid && s_rready;
  assign popBeat     = beatTaken && s_rlast;
  assign emptyRvalid = s_rvalid && !headValid;

  always_comb begin
    outVld_d  = outVld_q;
    outUser_d = outUser_q;
    outData_d = outData_q;
    outResp_d = outResp_q;
    outLast_d = outLast_q;
    if (beatTaken) begin
      outVld_d  = 1'b1;
      outUser_d = headUser;
      outData_d = s_rdata;
      outResp_d = s_rresp;
      outLast_d = s_rlast;
    end else if (outAccept) begin
      outVld_d = 1'b0;
    end
  end

  // The empty-rvalid counter saturates at the limit so the error fires once per episode.
  always_comb begin
    emptyCnt_d = '0;
    if (emptyRvalid) begin
      emptyCnt_d = (emptyCnt_q == CNT_W'(EMPTY_RVALID_LIMIT)) ? emptyCnt_q
                                                              : emptyCnt_q + CNT_W'(1);
    end
    err_d = (ar_push && ar_full) ||
            (emptyRvalid && (emptyCnt_q == CNT_W'(EMPTY_RVALID_LIMIT - 1)));
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      outVld_q   <= 1'b0;
      outUser_q  <= '0;
      outData_q  <= '0;
      outResp_q  <= RESP_OKAY;
      outLast_q  <= 1'b0;
      emptyCnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      outVld_q   <= outVld_d;
      outUser_q  <= outUser_d;
      outData_q  <= outData_d;
      outResp_q  <= outResp_d;
      outLast_q  <= outLast_d;
      emptyCnt_q <= emptyCnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    m_rvalid            = '0;
    m_rvalid[outUser_q] = outVld_q;
  end

  assign m_rdata   = outData_q;
  assign m_rresp   = outResp_q;
  assign m_rlast   = outLast_q;
  assign err_unexp = err_q;

endmodule
